// File: rtl/tile_map_renderer.sv
// tile_map_renderer
//   Pixel-generation stage for the robot playfield. It looks up a
//   20x15 map of 32x32-pixel tiles in a double-buffered map, converts
//   the tile codes to 3-bit RGB, and delays the raw syncs so that they
//   stay aligned with the colour output. Game logic writes the back bank.
//   A requested bank swap is applied at the start of vertical blanking.
//
// Ports
//   clock_50            system clock, rising edge
//   reset_key           synchronous active-high reset
//   p_tick              pixel-enable strobe; the pipeline only advances on it
//   pixel_x, pixel_y    current pixel coordinates from the sync generator
//   video_on            high inside the 640x480 active area
//   hsync_in, vsync_in  raw sync pulses (active low)
//   wr_en, wr_col,
//   wr_row, wr_code     back-bank tile write port (col 0..19, row 0..14)
//   swap_req            one-cycle request to swap front and back banks
//   swap_done           one-cycle pulse when the swap takes effect
//   vga_hs, vga_vs      syncs delayed to match rgb
//   rgb                 {R,G,B} pixel colour
module tile_map_renderer (
    input  logic       clock_50,
    input  logic       reset_key,
    input  logic       p_tick,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       wr_en,
    input  logic [4:0] wr_col,
    input  logic [3:0] wr_row,
    input  logic [2:0] wr_code,
    input  logic       swap_req,
    output logic       swap_done,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [2:0] rgb
);

    typedef enum logic {IDLE, PENDING} swap_state_t;

    localparam int unsigned MAP_SIZE = 300;

    // row*20 + col, computed with shifts and adds
    function automatic logic [8:0] map_addr(input logic [4:0] col, input logic [3:0] row);
        logic [8:0] r;
        r = {5'd0, row};
        return (r << 4) + (r << 2) + {4'd0, col};
    endfunction

    // ---------------------------------------------------------------
    // Tile map banks (not cleared by reset)
    // ---------------------------------------------------------------
    logic [2:0] bank0 [0:MAP_SIZE-1];
    logic [2:0] bank1 [0:MAP_SIZE-1];

    logic       front_sel;
    logic       wr_ok;
    logic [8:0] wr_addr;

    assign wr_ok   = wr_en && (wr_col <= 5'd19) && (wr_row <= 4'd14);
    assign wr_addr = map_addr(wr_col, wr_row);

    // Writes go to the bank that is not displayed. On the swap cycle,
    // front_sel still holds its old value, so such a write lands in the
    // bank that is about to become front.
    always_ff @(posedge clock_50) begin
        if (wr_ok) begin
            if (front_sel) bank0[wr_addr] <= wr_code;
            else           bank1[wr_addr] <= wr_code;
        end
    end

    // ---------------------------------------------------------------
    // Swap FSM
    // ---------------------------------------------------------------
    swap_state_t state, state_next;
    logic        vblank_edge;
    logic        do_swap;

    assign vblank_edge = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd480);

    always_comb begin
        state_next = state;
        do_swap    = 1'b0;
        case (state)
            IDLE: begin
                // A request on the vblank-edge cycle only arms the FSM. It is
                // applied at the next frame's vblank.
                if (swap_req) state_next = PENDING;
            end
            PENDING: begin
                if (vblank_edge) begin
                    state_next = IDLE;
                    do_swap    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset_key) begin
            state     <= IDLE;
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_next;
            swap_done <= do_swap;
            if (do_swap) front_sel <= ~front_sel;
        end
    end

    // ---------------------------------------------------------------
    // Pixel pipeline (advances only on p_tick)
    // ---------------------------------------------------------------
    logic [8:0] s1_addr;
    logic       s1_in_map;
    logic [4:0] s1_off_x, s1_off_y;
    logic       s1_video_on, s1_hs, s1_vs;

    logic [2:0] s2_code;
    logic [4:0] s2_off_x, s2_off_y;
    logic       s2_video_on, s2_hs, s2_vs;

    always_ff @(posedge clock_50) begin
        if (reset_key) begin
            s1_addr     <= '0;
            s1_in_map   <= 1'b0;
            s1_off_x    <= '0;
            s1_off_y    <= '0;
            s1_video_on <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s2_code     <= '0;
            s2_off_x    <= '0;
            s2_off_y    <= '0;
            s2_video_on <= 1'b0;
            s2_hs       <= 1'b1;
            s2_vs       <= 1'b1;
        end else if (p_tick) begin
            s1_addr     <= map_addr(pixel_x[9:5], pixel_y[8:5]);
            // Blanking coordinates can fall outside the map. Such pixels read
            // as floor (code 0) instead of indexing past the bank.
            s1_in_map   <= (pixel_x[9:5] <= 5'd19) && !pixel_y[9] && (pixel_y[8:5] <= 4'd14);
            s1_off_x    <= pixel_x[4:0];
            s1_off_y    <= pixel_y[4:0];
            s1_video_on <= video_on;
            s1_hs       <= hsync_in;
            s1_vs       <= vsync_in;

            if (!s1_in_map)     s2_code <= '0;
            else if (front_sel) s2_code <= bank1[s1_addr];
            else                s2_code <= bank0[s1_addr];
            s2_off_x    <= s1_off_x;
            s2_off_y    <= s1_off_y;
            s2_video_on <= s1_video_on;
            s2_hs       <= s1_hs;
            s2_vs       <= s1_vs;
        end
    end

    // ---------------------------------------------------------------
    // Output stage: palette lookup from the S2 registers
    // ---------------------------------------------------------------
    logic robot_rim;

    assign robot_rim = (s2_off_x < 5'd4) || (s2_off_x > 5'd27) ||
                       (s2_off_y < 5'd4) || (s2_off_y > 5'd27);

    always_comb begin
        rgb = 3'b000;
        if (s2_video_on) begin
            case (s2_code)
                3'd0:    rgb = 3'b000;
                3'd1:    rgb = 3'b111;
                3'd2:    rgb = 3'b110;
                3'd3:    rgb = 3'b010;
                3'd4:    rgb = robot_rim ? 3'b100 : 3'b001;
                default: rgb = 3'b101;
            endcase
        end
    end

    assign vga_hs = s2_hs;
    assign vga_vs = s2_vs;

endmodule

// File: tb/tb_tile_map_renderer.sv
// tb_tile_map_renderer
//   Directed bench for tile_map_renderer. It uses hand-computed expected
//   colours and sync/swap behaviour. The bench drives pixel coordinates
//   directly instead of modelling a full sync generator.
module tb_tile_map_renderer;

    logic       clock_50;
    logic       reset_key;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       wr_en;
    logic [4:0] wr_col;
    logic [3:0] wr_row;
    logic [2:0] wr_code;
    logic       swap_req;
    logic       swap_done;
    logic       vga_hs;
    logic       vga_vs;
    logic [2:0] rgb;

    int unsigned n_checks;
    int unsigned n_pass;

    tile_map_renderer dut (
        .clock_50  (clock_50),
        .reset_key (reset_key),
        .p_tick    (p_tick),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_code   (wr_code),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .rgb       (rgb)
    );

    initial clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock_50);
        #1;
    endtask

    task automatic write_tile(input logic [4:0] col, input logic [3:0] row, input logic [2:0] code);
        wr_en   = 1'b1;
        wr_col  = col;
        wr_row  = row;
        wr_code = code;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic fill_back_zero();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
                write_tile(5'(c), 4'(r), 3'd0);
    endtask

    // Hold one pixel for two ticks, then compare rgb.
    task automatic render(input string tag, input int x, input int y, input logic von,
                          input logic [2:0] exp);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        p_tick   = 1'b1;
        step();
        step();
        p_tick   = 1'b0;
        check(tag, 32'(rgb), 32'(exp));
    endtask

    task automatic pulse_swap_req();
        pixel_x  = 10'd0;
        pixel_y  = 10'd100;
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    // One tick on the vblank-edge pixel. swap_done is high on the following
    // cycle only when a swap is applied.
    task automatic vblank(input string tag, input logic req, input logic exp_done);
        pixel_x  = 10'd0;
        pixel_y  = 10'd480;
        video_on = 1'b0;
        p_tick   = 1'b1;
        swap_req = req;
        step();
        swap_req = 1'b0;
        check({tag, "_done"}, 32'(swap_done), 32'(exp_done));
        pixel_y  = 10'd481;
        step();
        p_tick   = 1'b0;
        check({tag, "_pulse_end"}, 32'(swap_done), 32'd0);
        pixel_y  = 10'd0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset_key = 1'b1;
        p_tick    = 1'b0;
        pixel_x   = '0;
        pixel_y   = '0;
        video_on  = 1'b0;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        wr_en     = 1'b0;
        wr_col    = '0;
        wr_row    = '0;
        wr_code   = '0;
        swap_req  = 1'b0;

        // Reset state
        step();
        p_tick = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        video_on = 1'b1;
        step();
        step();
        check("rst_hs", 32'(vga_hs), 32'd1);
        check("rst_vs", 32'(vga_vs), 32'd1);
        check("rst_rgb", 32'(rgb), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        p_tick   = 1'b0;
        reset_key = 1'b0;
        step();

        // Clear both banks through the back-bank port.
        fill_back_zero();
        pulse_swap_req();
        vblank("init_swap1", 1'b0, 1'b1);
        fill_back_zero();
        pulse_swap_req();
        vblank("init_swap2", 1'b0, 1'b1);
        render("px00_initial", 0, 0, 1'b1, 3'b000);

        // A back-bank write is invisible until the swap.
        write_tile(5'd0, 4'd0, 3'd1);
        render("wall_before_swap", 0, 0, 1'b1, 3'b000);
        pulse_swap_req();
        pixel_y = 10'd100;
        p_tick  = 1'b1;
        step();
        check("no_early_swap", 32'(swap_done), 32'd0);
        pixel_y = 10'd479;
        step();
        check("no_swap_479", 32'(swap_done), 32'd0);
        p_tick = 1'b0;
        render("wall_pending", 0, 0, 1'b1, 3'b000);
        vblank("swap_wall", 1'b0, 1'b1);
        render("wall_after_swap", 5, 5, 1'b1, 3'b111);

        // Robot tile and the remaining palette codes go into the new back bank.
        write_tile(5'd2, 4'd1, 3'd4);
        write_tile(5'd3, 4'd0, 3'd2);
        write_tile(5'd4, 4'd0, 3'd3);
        write_tile(5'd5, 4'd0, 3'd7);
        pulse_swap_req();
        vblank("swap_robot", 1'b0, 1'b1);
        render("bank0_px00", 0, 0, 1'b1, 3'b000);
        render("robot_xoff3", 67, 35, 1'b1, 3'b100);
        render("robot_center", 80, 48, 1'b1, 3'b001);
        render("robot_xoff28", 92, 60, 1'b1, 3'b100);
        render("robot_yoff2", 80, 34, 1'b1, 3'b100);
        render("dirt", 106, 10, 1'b1, 3'b110);
        render("pipe", 138, 10, 1'b1, 3'b010);
        render("invalid", 170, 10, 1'b1, 3'b101);

        // Out-of-range writes are dropped. Col 20 of row 3 would alias to address 80.
        write_tile(5'd20, 4'd3, 3'd2);
        write_tile(5'd0, 4'd15, 3'd2);
        pulse_swap_req();
        vblank("swap_oor", 1'b0, 1'b1);
        render("oor_tile_0_4", 5, 133, 1'b1, 3'b000);
        render("bank1_wall", 5, 5, 1'b1, 3'b111);

        // Blanking forces black. Syncs arrive two ticks late, and the pipeline
        // holds them while p_tick is low.
        render("blank_black", 5, 5, 1'b0, 3'b000);
        pixel_x  = 10'd5;
        pixel_y  = 10'd5;
        video_on = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        p_tick   = 1'b1;
        step();
        check("hs_after_1tick", 32'(vga_hs), 32'd1);
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        p_tick   = 1'b0;
        step();
        check("hs_hold", 32'(vga_hs), 32'd1);
        p_tick   = 1'b1;
        step();
        check("hs_after_2ticks", 32'(vga_hs), 32'd0);
        check("vs_after_2ticks", 32'(vga_vs), 32'd0);
        check("rgb_aligned", 32'(rgb), 32'd7);
        step();
        check("hs_restored", 32'(vga_hs), 32'd1);
        check("vs_restored", 32'(vga_vs), 32'd1);
        p_tick   = 1'b0;

        // Two requests in one frame produce a single swap.
        pulse_swap_req();
        pulse_swap_req();
        vblank("double_req", 1'b0, 1'b1);
        vblank("double_req_next", 1'b0, 1'b0);
        render("after_double", 106, 10, 1'b1, 3'b110);

        // A request on the vblank-edge cycle waits for the next frame.
        vblank("req_on_edge", 1'b1, 1'b0);
        vblank("req_on_edge_next", 1'b0, 1'b1);
        render("after_edge_req", 106, 10, 1'b1, 3'b000);

        // A reset while PENDING drops the request and returns to bank 0.
        pulse_swap_req();
        reset_key = 1'b1;
        step();
        check("mid_rst_rgb", 32'(rgb), 32'd0);
        check("mid_rst_hs", 32'(vga_hs), 32'd1);
        reset_key = 1'b0;
        vblank("after_reset", 1'b0, 1'b0);
        render("bank0_after_reset", 106, 10, 1'b1, 3'b110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
